// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arith/SLT ops plus an iterative
// 32-step signed shift-add multiplier writing Hi/Lo, with Start/Busy/Done handshake.
module seq_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AluS,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  output logic [31:0] Result,
  output logic        Zero,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t            state, state_nxt;
  logic [2*W-1:0]    mcand, acc, product;
  logic [W-1:0]      mplier, abs_a, abs_b, alu_res;
  logic [CW-1:0]     cnt;
  logic              sign, mul_load;
  logic [W-1:0]      result_nxt, hi_nxt, lo_nxt;
  logic              zero_nxt, done_nxt, busy_nxt;

  // Magnitudes as unsigned; |0x80000000| naturally becomes 2^31.
  assign abs_a   = A[W-1] ? (~A + W'(1)) : A;
  assign abs_b   = B[W-1] ? (~B + W'(1)) : B;
  assign product = sign ? (~acc + (2*W)'(1)) : acc;

  always_comb begin
    case (AluS)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = W'($signed(A) < $signed(B));
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start && AluS == OP_MULT) state_nxt = MUL;
      MUL:     if (cnt == CW'(W - 1))        state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    result_nxt = Result;
    zero_nxt   = Zero;
    hi_nxt     = Hi;
    lo_nxt     = Lo;
    done_nxt   = 1'b0;
    busy_nxt   = (state_nxt != IDLE);
    mul_load   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (AluS == OP_MULT) begin
            mul_load = 1'b1;
          end else begin
            result_nxt = alu_res;
            zero_nxt   = (alu_res == '0);
            done_nxt   = 1'b1;
          end
        end
      end
      FIX: begin
        hi_nxt     = product[2*W-1:W];
        lo_nxt     = product[W-1:0];
        result_nxt = product[W-1:0];
        zero_nxt   = (product[W-1:0] == '0);
        done_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result <= '0;
      Zero   <= 1'b1;
      Hi     <= '0;
      Lo     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Result <= result_nxt;
      Zero   <= zero_nxt;
      Hi     <= hi_nxt;
      Lo     <= lo_nxt;
      Busy   <= busy_nxt;
      Done   <= done_nxt;
    end
  end

  // Shift-add datapath: one multiplier bit per MUL cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else if (mul_load) begin
      mcand  <= {{W{1'b0}}, abs_a};
      mplier <= abs_b;
      acc    <= '0;
      cnt    <= '0;
      sign   <= A[W-1] ^ B[W-1];
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: randomized and directed ops checked against
// an arithmetic reference model (64-bit signed multiply for MULT).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  AluS;
  logic [31:0] A, B;
  logic        Start;
  logic [31:0] Result, Hi, Lo;
  logic        Zero, Busy, Done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  seq_alu dut (
    .clk(clk), .rst_n(rst_n), .AluS(AluS), .A(A), .B(B), .Start(Start),
    .Result(Result), .Zero(Zero), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'b0011) op = 4'b0010;
    return op;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b0; AluS = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Result, Zero, Hi, Lo, Busy, Done} !== {32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: Result=%h Zero=%b Hi=%h Lo=%h Busy=%b Done=%b", Result, Zero, Hi, Lo, Busy, Done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single-cycle op: Start for one cycle, result and Done in the next cycle only.
  task automatic run_single(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    er = ref_alu(op, a, b);
    AluS = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    checks++;
    if ({Result, Zero, Done, Busy, Hi, Lo} !== {er, (er == 32'd0), 1'b1, 1'b0, exp_hi, exp_lo}) begin
      failures++;
      $display("FAIL %s op=%b a=%h b=%h: Result=%h Zero=%b Done=%b Busy=%b Hi=%h Lo=%h, want Result=%h Zero=%b Done=1 Busy=0 Hi=%h Lo=%h",
               name, op, a, b, Result, Zero, Done, Busy, Hi, Lo, er, (er == 32'd0), exp_hi, exp_lo);
    end
    @(negedge clk);
    checks++;
    if ({Done, Result} !== {1'b0, er}) begin
      failures++;
      $display("FAIL %s_hold: Done=%b Result=%h, want Done=0 Result=%h", name, Done, Result, er);
    end
  endtask

  task automatic test_single();
    run_single("add_7_5",   4'b0010, 32'd7, 32'd5);
    run_single("sub_5_5",   4'b0110, 32'd5, 32'd5);
    run_single("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_single("slt_pos",   4'b0111, 32'd1, 32'hFFFF_FFFF);
    run_single("undef_f",   4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    run_single("and",       4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_single("or",        4'b0001, 32'hF000_0000, 32'h0000_000F);
    run_single("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'd1);
    run_single("slt_eq",    4'b0111, 32'h8000_0000, 32'h8000_0000);
    run_single("slt_min",   4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
    for (int i = 0; i < 30; i++) run_single("rand_single", rand_op(), $urandom, $urandom);
  endtask

  // MULT: 33 Busy cycles, then one Done cycle with Hi/Lo/Result written.
  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input bit chain);
    logic [63:0] ep;
    int n;
    ep = ref_mul(a, b);
    AluS = 4'b0011; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      AluS = rand_op(); A = $urandom; B = $urandom;
      Start = inject && (n == 5);
      checks++;
      if (Done !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
        failures++;
        $display("FAIL %s_busy cyc=%0d: Done=%b Hi=%h Lo=%h, want Done=0 Hi=%h Lo=%h", name, n, Done, Hi, Lo, exp_hi, exp_lo);
      end
      @(negedge clk);
      Start = 1'b0;
      n++;
    end
    exp_hi = ep[63:32];
    exp_lo = ep[31:0];
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL %s_busy_len: busy cycles=%0d, want 33", name, n);
    end
    checks++;
    if ({Done, Busy, Hi, Lo, Result, Zero} !== {1'b1, 1'b0, exp_hi, exp_lo, exp_lo, (exp_lo == 32'd0)}) begin
      failures++;
      $display("FAIL %s a=%h b=%h: Done=%b Busy=%b Hi=%h Lo=%h Result=%h Zero=%b, want Done=1 Busy=0 Hi=%h Lo=%h Result=%h Zero=%b",
               name, a, b, Done, Busy, Hi, Lo, Result, Zero, exp_hi, exp_lo, exp_lo, (exp_lo == 32'd0));
    end
    if (chain) begin
      run_single("add_on_done", 4'b0010, 32'd100, 32'd23);
    end else begin
      @(negedge clk);
      checks++;
      if ({Done, Busy, Result} !== {1'b0, 1'b0, exp_lo}) begin
        failures++;
        $display("FAIL %s_after: Done=%b Busy=%b Result=%h, want Done=0 Busy=0 Result=%h", name, Done, Busy, Result, exp_lo);
      end
    end
  endtask

  task automatic test_mult();
    run_mult("mul_m3_7",   32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_mult("mul_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_mult("mul_min_1",  32'h8000_0000, 32'd1, 1'b0, 1'b0);
    run_mult("mul_zero",   32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_mult("mul_m1_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) run_mult("mul_rand", $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_busy_start();
    run_mult("mul_inject", 32'h0001_2345, 32'hFFFF_F001, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic [3:0]  op;
    logic [31:0] a, b;
    op = rand_op(); a = $urandom; b = $urandom;
    AluS = op; A = a; B = b; Start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      er = ref_alu(op, a, b);
      @(negedge clk);
      op = rand_op(); a = $urandom; b = $urandom;
      AluS = op; A = a; B = b; Start = (i < 11);
      checks++;
      if ({Result, Zero, Done, Busy} !== {er, (er == 32'd0), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL b2b[%0d]: Result=%h Zero=%b Done=%b Busy=%b, want Result=%h Zero=%b Done=1 Busy=0",
                 i, Result, Zero, Done, Busy, er, (er == 32'd0));
      end
    end
    Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mult();
    bit saw_done;
    AluS = 4'b0011; A = 32'h0012_3456; B = 32'h0000_0777; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if ({Busy, Done, Hi, Lo, Result, Zero} !== {1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid: Busy=%b Done=%b Hi=%h Lo=%h Result=%h Zero=%b, want all cleared",
               Busy, Done, Hi, Lo, Result, Zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done !== 1'b0 || Busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_mid_nodone: Done/Busy seen after aborted multiply, want none");
    end
    run_mult("mul_6_7", 32'd6, 32'd7, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_mult();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
